run_ctrl: RTL

Synthesizable run controller and data-memory write tracer for `processor_arm`. It sequences the processor reset, the run window and the `dump` strobe from parameters. It also captures every data-memory write of the run window into a trace FIFO, so a bench or on-board debug logic can check results without fixed-delay stimulus. It sits beside `processor_arm`: it drives the core's reset and `dump` inputs and taps the `DM_writeData`, `DM_addr` and `DM_writeEnable` outputs.

---
 rtl/run_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer and data-memory write tracer for processor_arm.
// Optional macro RUN_CTRL_ADDR_FILTER_EN limits capture to FILTER_LO..FILTER_HI.
module run_ctrl #(
  parameter int          N            = 64,
  parameter int          RESET_CYCLES = 2,
  parameter int          RUN_CYCLES   = 50,
  parameter int          DUMP_CYCLES  = 2,
  parameter int          TRACE_DEPTH  = 16,
  parameter logic [N-1:0] FILTER_LO   = '0,
  parameter logic [N-1:0] FILTER_HI   = {N{1'b1}}
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             start,
  output logic                             core_reset,
  output logic                             dump,
  input  logic                             DM_writeEnable,
  input  logic [N-1:0]                     DM_addr,
  input  logic [N-1:0]                     DM_writeData,
  input  logic                             trace_rd,
  output logic                             trace_valid,
  output logic [N-1:0]                     trace_addr,
  output logic [N-1:0]                     trace_data,
  output logic [$clog2(TRACE_DEPTH+1)-1:0] trace_count,
  output logic                             overflow,
  output logic [31:0]                      write_count,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = $clog2(TRACE_DEPTH + 1);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(TRACE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_DUMP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   wcnt_q, wcnt_d;

  logic [N-1:0]  mem_addr_q [TRACE_DEPTH];
  logic [N-1:0]  mem_data_q [TRACE_DEPTH];

  logic start_acc, in_range, capture;
  logic full, pop, push;

  assign start_acc = start &&
    (state_q == S_IDLE || state_q == S_DONE);

`ifdef RUN_CTRL_ADDR_FILTER_EN
  assign in_range = (DM_addr >= FILTER_LO) &&
                    (DM_addr <= FILTER_HI);
`else
  logic unused_filter;
  assign unused_filter = ^{FILTER_LO, FILTER_HI};
  assign in_range = 1'b1;
`endif

  assign capture = (state_q == S_RUN) &&
                   DM_writeEnable && in_range;
  assign full    = (count_q == FULL);
  assign pop     = trace_rd && (count_q != '0);
  // a full FIFO still accepts a push when a pop frees a slot
  assign push    = capture && (!full || pop);

  // state register and phase cycle counter
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // next state: each timed phase ends after its cycle count
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 32'd1;
    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (start) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cyc_q == 32'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
          cyc_d   = '0;
        end
      end
      S_RUN: begin
        if (cyc_q == 32'(RUN_CYCLES - 1)) begin
          state_d = S_DUMP;
          cyc_d   = '0;
        end
      end
      S_DUMP: begin
        if (cyc_q == 32'(DUMP_CYCLES - 1)) begin
          state_d = S_DONE;
          cyc_d   = '0;
        end
      end
      S_DONE: begin
        cyc_d = '0;
        if (start) state_d = S_HOLD;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // control outputs decoded from the current state
  always_comb begin
    core_reset = (state_q == S_IDLE) || (state_q == S_HOLD);
    dump       = (state_q == S_DUMP);
    busy       = (state_q == S_HOLD) || (state_q == S_RUN) ||
                 (state_q == S_DUMP);
    done       = (state_q == S_DONE);
  end

  // FIFO bookkeeping; an accepted start flushes everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    wcnt_d   = wcnt_q;
    if (start_acc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      wcnt_d   = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (capture && !push) ovf_d = 1'b1;
      if (capture && wcnt_q != '1)
        wcnt_d = wcnt_q + 32'd1;
    end
  end

  // FIFO control registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // trace storage; contents are don't-care until pushed
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= DM_addr;
      mem_data_q[wr_ptr_q] <= DM_writeData;
    end
  end

  assign trace_valid = (count_q != '0);
  assign trace_addr  = mem_addr_q[rd_ptr_q];
  assign trace_data  = mem_data_q[rd_ptr_q];
  assign trace_count = count_q;
  assign overflow    = ovf_q;
  assign write_count = wcnt_q;

endmodule
